// File: rtl/tdm_demux_14_if.sv
// tdm_demux_14_if: slot stream in, four channel outputs plus frame status out.
interface tdm_demux_14_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] din;
  logic in_valid;
  logic sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic out_valid;
  logic [1:0] s;
  logic locked;
  logic sync_err;
  modport master (output din, in_valid, sync, input a, b, c, d, out_valid, s, locked, sync_err);
  modport slave (input din, in_valid, sync, output a, b, c, d, out_valid, s, locked, sync_err);
endinterface

// File: rtl/tdm_demux_14.sv
// tdm_demux_14: 4-slot TDM demux locking on slot-0 sync; DEMUX_STRICT_SYNC_EN drops lock when slot 0 lacks sync.
module tdm_demux_14 #(parameter int WIDTH = 1) (
  input logic clk,
  input logic rst_n,
  tdm_demux_14_if.slave bus
);
  typedef enum logic {HUNT, LOCKED} state_t;
  state_t r_state, w_state;
  logic [1:0] r_s, w_s;
  logic [WIDTH-1:0] r_sh0, r_sh1, r_sh2, w_sh0, w_sh1, w_sh2;
  logic [WIDTH-1:0] r_a, r_b, r_c, r_d, w_a, w_b, w_c, w_d;
  logic r_ov, w_ov, r_err, w_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= HUNT;
      r_s <= 2'd0;
      r_sh0 <= '0;
      r_sh1 <= '0;
      r_sh2 <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
      r_ov <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_s <= w_s;
      r_sh0 <= w_sh0;
      r_sh1 <= w_sh1;
      r_sh2 <= w_sh2;
      r_a <= w_a;
      r_b <= w_b;
      r_c <= w_c;
      r_d <= w_d;
      r_ov <= w_ov;
      r_err <= w_err;
    end
  end
  always_comb begin
    w_state = r_state;
    w_s = r_s;
    w_sh0 = r_sh0;
    w_sh1 = r_sh1;
    w_sh2 = r_sh2;
    w_a = r_a;
    w_b = r_b;
    w_c = r_c;
    w_d = r_d;
    w_ov = 1'b0;
    w_err = 1'b0;
    if (bus.in_valid) begin
      if (r_state == HUNT) begin
        if (bus.sync) begin
          w_state = LOCKED;
          w_sh0 = bus.din;
          w_s = 2'd1;
        end
      end else if (bus.sync || r_s == 2'd0) begin
        // any sync restarts the frame; sync away from slot 0 also flags an error
`ifdef DEMUX_STRICT_SYNC_EN
        if (!bus.sync) begin
          w_state = HUNT;
          w_s = 2'd0;
          w_err = 1'b1;
        end else begin
`else
        begin
`endif
          w_err = bus.sync && r_s != 2'd0;
          w_sh0 = bus.din;
          w_s = 2'd1;
        end
      end else if (r_s == 2'd3) begin
        w_a = r_sh0;
        w_b = r_sh1;
        w_c = r_sh2;
        w_d = bus.din;
        w_ov = 1'b1;
        w_s = 2'd0;
      end else begin
        w_sh1 = r_s == 2'd1 ? bus.din : r_sh1;
        w_sh2 = r_s == 2'd2 ? bus.din : r_sh2;
        w_s = r_s + 2'd1;
      end
    end
  end
  always_comb begin
    bus.a = r_a;
    bus.b = r_b;
    bus.c = r_c;
    bus.d = r_d;
    bus.out_valid = r_ov;
    bus.sync_err = r_err;
    bus.s = r_s;
    bus.locked = r_state == LOCKED;
  end
endmodule

// File: tb/tb_tdm_demux_14.sv
// tb_tdm_demux_14: directed scenarios for the 4-slot TDM demux.
module tb_tdm_demux_14;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  tdm_demux_14_if #(.WIDTH(1)) bus ();
  tdm_demux_14 #(.WIDTH(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic send(input logic din_v, input logic sync_v);
    bus.in_valid = 1'b1;
    bus.din = din_v;
    bus.sync = sync_v;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.sync = 1'b0;
  endtask
  task automatic idle(input logic sync_v);
    bus.in_valid = 1'b0;
    bus.sync = sync_v;
    @(posedge clk);
    #1;
    bus.sync = 1'b0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    bus.din = 1'b0;
    bus.in_valid = 1'b0;
    bus.sync = 1'b0;
    rst_n = 1'b0;
    #12;
    n_checks++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.out_valid, bus.sync_err, bus.locked, bus.s} !== 9'b0) begin
      n_fail++;
      $display("FAIL reset_state got=%b want=%b", {bus.a, bus.b, bus.c, bus.d, bus.out_valid, bus.sync_err, bus.locked, bus.s}, 9'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_basic();
    send(1'b1, 1'b1);
    n_checks++;
    if ({bus.locked, bus.s} !== 3'b101) begin
      n_fail++;
      $display("FAIL basic_lock got=%b want=%b", {bus.locked, bus.s}, 3'b101);
    end
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_early_ov got=%b want=0", bus.out_valid);
    end
    send(1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.c, bus.d, bus.locked, bus.s} !== 8'b1_1000_1_00) begin
      n_fail++;
      $display("FAIL basic_frame got=%b want=%b", {bus.out_valid, bus.a, bus.b, bus.c, bus.d, bus.locked, bus.s}, 8'b1_1000_1_00);
    end
    idle(1'b0);
    n_checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.c, bus.d} !== 5'b0_1000) begin
      n_fail++;
      $display("FAIL basic_pulse_hold got=%b want=%b", {bus.out_valid, bus.a, bus.b, bus.c, bus.d}, 5'b0_1000);
    end
  endtask
  task automatic test_back_to_back();
    logic [7:0] seq;
    seq = 8'b0110_1001;
    for (int i = 0; i < 8; i++) begin
      send(seq[7-i], i % 4 == 0);
      n_checks++;
      if (bus.out_valid !== (i % 4 == 3)) begin
        n_fail++;
        $display("FAIL b2b_ov[%0d] got=%b want=%b", i, bus.out_valid, i % 4 == 3);
      end
      if (i == 3 || i == 7) begin
        n_checks++;
        if ({bus.a, bus.b, bus.c, bus.d} !== (i == 3 ? seq[7:4] : seq[3:0])) begin
          n_fail++;
          $display("FAIL b2b_data[%0d] got=%b want=%b", i, {bus.a, bus.b, bus.c, bus.d}, i == 3 ? seq[7:4] : seq[3:0]);
        end
      end
    end
  endtask
  task automatic test_hunt();
    logic [3:0] junk;
    logic [3:0] frame;
    int n_ov;
    junk = 4'b1101;
    frame = 4'b0110;
    n_ov = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(junk[3-i], 1'b0);
      n_ov += int'(bus.out_valid);
      n_checks++;
      if ({bus.locked, bus.s} !== 3'b000) begin
        n_fail++;
        $display("FAIL hunt_ignore[%0d] got=%b want=000", i, {bus.locked, bus.s});
      end
    end
    for (int i = 0; i < 4; i++) begin
      send(frame[3-i], i == 0);
      n_ov += int'(bus.out_valid);
    end
    idle(1'b0);
    n_ov += int'(bus.out_valid);
    n_checks++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 4'b0110 || n_ov != 1) begin
      n_fail++;
      $display("FAIL hunt_frame got=%b ov_pulses=%0d want=0110 ov_pulses=1", {bus.a, bus.b, bus.c, bus.d}, n_ov);
    end
  endtask
  task automatic test_stall();
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      n_checks++;
      if ({bus.locked, bus.s, bus.out_valid} !== 4'b1_10_0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d] got=%b want=1100", i, {bus.locked, bus.s, bus.out_valid});
      end
    end
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.c, bus.d} !== 5'b1_1010) begin
      n_fail++;
      $display("FAIL stall_frame got=%b want=%b", {bus.out_valid, bus.a, bus.b, bus.c, bus.d}, 5'b1_1010);
    end
  endtask
  task automatic test_early_sync();
    send(1'b1, 1'b1);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    n_checks++;
    if ({bus.sync_err, bus.out_valid, bus.a, bus.b, bus.c, bus.d, bus.s} !== 8'b1_0_1010_01) begin
      n_fail++;
      $display("FAIL early_sync_err got=%b want=%b", {bus.sync_err, bus.out_valid, bus.a, bus.b, bus.c, bus.d, bus.s}, 8'b1_0_1010_01);
    end
    idle(1'b0);
    n_checks++;
    if (bus.sync_err !== 1'b0) begin
      n_fail++;
      $display("FAIL early_sync_pulse got=%b want=0", bus.sync_err);
    end
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.c, bus.d} !== 5'b1_0010) begin
      n_fail++;
      $display("FAIL early_sync_frame got=%b want=%b", {bus.out_valid, bus.a, bus.b, bus.c, bus.d}, 5'b1_0010);
    end
  endtask
  task automatic test_slot0_nosync();
    send(1'b1, 1'b0);
`ifdef DEMUX_STRICT_SYNC_EN
    n_checks++;
    if ({bus.sync_err, bus.locked, bus.s, bus.out_valid} !== 5'b1_0_00_0) begin
      n_fail++;
      $display("FAIL strict_drop got=%b want=10000", {bus.sync_err, bus.locked, bus.s, bus.out_valid});
    end
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.locked, bus.a, bus.b, bus.c, bus.d} !== 6'b0_0_0010) begin
      n_fail++;
      $display("FAIL strict_no_frame got=%b want=000010", {bus.out_valid, bus.locked, bus.a, bus.b, bus.c, bus.d});
    end
`else
    n_checks++;
    if ({bus.sync_err, bus.locked, bus.s, bus.out_valid} !== 5'b0_1_01_0) begin
      n_fail++;
      $display("FAIL flywheel_slot0 got=%b want=01010", {bus.sync_err, bus.locked, bus.s, bus.out_valid});
    end
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.sync_err, bus.a, bus.b, bus.c, bus.d} !== 6'b1_0_1101) begin
      n_fail++;
      $display("FAIL flywheel_frame got=%b want=101101", {bus.out_valid, bus.sync_err, bus.a, bus.b, bus.c, bus.d});
    end
`endif
  endtask
  task automatic test_async_reset();
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    n_checks++;
    if (bus.s !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_setup got=%0d want=2", bus.s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.out_valid, bus.locked, bus.s} !== 8'b0) begin
      n_fail++;
      $display("FAIL areset_clear got=%b want=%b", {bus.a, bus.b, bus.c, bus.d, bus.out_valid, bus.locked, bus.s}, 8'b0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(1'b0, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    n_checks++;
    if ({bus.out_valid, bus.a, bus.b, bus.c, bus.d} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL areset_frame got=%b want=%b", {bus.out_valid, bus.a, bus.b, bus.c, bus.d}, 5'b1_0001);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_hunt();
    test_stall();
    test_early_sync();
    test_slot0_nosync();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
